// File: rtl/morse_key_sequencer_pkg.sv
// Shared key codes, FSM state encoding and sizing helpers for the Morse key sequencer.
package morse_key_sequencer_pkg;

    localparam logic [3:0] KEY_DOT    = 4'd1;
    localparam logic [3:0] KEY_DASH   = 4'd2;
    localparam logic [3:0] KEY_BKSP   = 4'd3;
    localparam logic [3:0] KEY_COMMIT = 4'd4;

    localparam int MAX_LEN = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TONE   = 2'd1,
        ST_GAP    = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/morse_key_sequencer_if.sv
// Keypad strobe, piezo/preview status and decoder valid/ready bundle.
interface morse_key_sequencer_if;

    logic [3:0] key_val;
    logic       key_trig;
    logic       tone_on;
    logic       busy;
    logic [2:0] sym_len;
    logic       code_valid;
    logic       code_ready;
    logic [4:0] code_bits;
    logic [2:0] code_len;
    logic       code_err;

    modport master (
        output key_val, key_trig, code_ready,
        input  tone_on, busy, sym_len, code_valid, code_bits, code_len, code_err
    );

    modport slave (
        input  key_val, key_trig, code_ready,
        output tone_on, busy, sym_len, code_valid, code_bits, code_len, code_err
    );

endinterface

// File: rtl/morse_key_sequencer_timer.sv
// Loadable down-counter that stops at zero; shared by the tone and gap phases.
module morse_key_sequencer_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_value;
        end else if (r_value != '0) begin
            r_value <= r_value - W'(1);
        end
    end

    assign o_zero = (r_value == '0);

endmodule

// File: rtl/morse_key_sequencer.sv
// Keypad front end: edge-detects keys, times element tones, buffers up to MAX_LEN
// elements and hands the finished symbol to the decoder over valid/ready.
module morse_key_sequencer
    import morse_key_sequencer_pkg::*;
#(
    parameter int TONE_DOT_CYCLES  = 500_000,
    parameter int TONE_DASH_CYCLES = 1_500_000,
    parameter int GAP_CYCLES       = 2_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    morse_key_sequencer_if.slave bus
);

    localparam int TIMER_W = $clog2(max3(TONE_DOT_CYCLES, TONE_DASH_CYCLES, GAP_CYCLES) + 1);
    // Timer is loaded with N-1 so that the phase lasts exactly N cycles.
    localparam logic [TIMER_W-1:0] DOT_LOAD  = TIMER_W'(TONE_DOT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DASH_LOAD = TIMER_W'(TONE_DASH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);

    state_t       r_state;
    logic         r_trig_q, r_key_evt;
    logic [3:0]   r_key_code;
    logic [4:0]   r_bits;
    logic [2:0]   r_len;
    logic         r_ovf;
    logic         r_tone_on, r_busy, r_code_valid, r_code_err;
    logic [4:0]   r_code_bits;
    logic [2:0]   r_code_len;

    logic               w_is_elem, w_is_dash, w_is_bksp, w_is_commit;
    logic               w_load, w_timer_zero;
    logic [TIMER_W-1:0] w_load_val;
    logic [4:0]         w_app_bits, w_bksp_bits;
    logic [2:0]         w_app_len;
    logic               w_app_ovf;

    assign w_is_dash   = (r_key_code == KEY_DASH);
    assign w_is_elem   = r_key_evt && ((r_key_code == KEY_DOT) || w_is_dash);
    assign w_is_bksp   = r_key_evt && (r_key_code == KEY_BKSP);
    assign w_is_commit = r_key_evt && (r_key_code == KEY_COMMIT);
    assign w_bksp_bits = r_bits & ~(5'd1 << (r_len - 3'd1));

    always_comb begin
        w_app_bits = r_bits;
        w_app_len  = r_len;
        w_app_ovf  = r_ovf;
        if (r_len == 3'(MAX_LEN)) begin
            w_app_ovf = 1'b1;
        end else begin
            w_app_bits = r_bits | (5'(w_is_dash) << r_len);
            w_app_len  = r_len + 3'd1;
        end
    end

    always_comb begin
        w_load     = 1'b0;
        w_load_val = GAP_LOAD;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                if (w_is_elem) begin
                    w_load     = 1'b1;
                    w_load_val = w_is_dash ? DASH_LOAD : DOT_LOAD;
                end else if (r_state == ST_GAP && w_is_bksp && r_len > 3'd1) begin
                    w_load = 1'b1;
                end
            end
            ST_TONE: w_load = w_timer_zero;
            default: w_load = 1'b0;
        endcase
    end

    morse_key_sequencer_timer #(.W(TIMER_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_zero  (w_timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_trig_q     <= 1'b0;
            r_key_evt    <= 1'b0;
            r_key_code   <= '0;
            r_bits       <= '0;
            r_len        <= '0;
            r_ovf        <= 1'b0;
            r_tone_on    <= 1'b0;
            r_busy       <= 1'b0;
            r_code_valid <= 1'b0;
            r_code_bits  <= '0;
            r_code_len   <= '0;
            r_code_err   <= 1'b0;
        end else begin
            r_trig_q   <= bus.key_trig;
            r_key_evt  <= bus.key_trig & ~r_trig_q;
            r_key_code <= bus.key_val;
            case (r_state)
                ST_IDLE: begin
                    if (w_is_elem) begin
                        r_bits    <= w_app_bits;
                        r_len     <= w_app_len;
                        r_ovf     <= w_app_ovf;
                        r_tone_on <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_TONE;
                    end else if (w_is_commit) begin
                        r_code_bits  <= r_bits;
                        r_code_len   <= r_len;
                        r_code_err   <= r_ovf;
                        r_code_valid <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_COMMIT;
                    end
                end
                ST_TONE: begin
                    if (w_timer_zero) begin
                        r_tone_on <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // A new element beats gap expiry in the same cycle.
                    if (w_is_elem) begin
                        r_bits    <= w_app_bits;
                        r_len     <= w_app_len;
                        r_ovf     <= w_app_ovf;
                        r_tone_on <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_TONE;
                    end else if (w_is_bksp) begin
                        r_bits <= w_bksp_bits;
                        r_len  <= r_len - 3'd1;
                        if (r_len == 3'd1) r_state <= ST_IDLE;
                    end else if (w_is_commit || w_timer_zero) begin
                        r_code_bits  <= r_bits;
                        r_code_len   <= r_len;
                        r_code_err   <= r_ovf;
                        r_code_valid <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (r_code_valid && bus.code_ready) begin
                        r_code_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_bits       <= '0;
                        r_len        <= '0;
                        r_ovf        <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.tone_on    = r_tone_on;
    assign bus.busy       = r_busy;
    assign bus.sym_len    = r_len;
    assign bus.code_valid = r_code_valid;
    assign bus.code_bits  = r_code_bits;
    assign bus.code_len   = r_code_len;
    assign bus.code_err   = r_code_err;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Scoreboard bench for morse_key_sequencer with short tone/gap timing.
module tb_morse_key_sequencer;

    localparam int DOT_N  = 4;
    localparam int DASH_N = 12;
    localparam int GAP_N  = 40;

    localparam logic [3:0] K_DOT = 4'd1, K_DASH = 4'd2, K_BKSP = 4'd3, K_COMMIT = 4'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [8:0] sb_q[$];
    logic [4:0] m_bits;
    logic [2:0] m_len;
    logic       m_ovf;

    morse_key_sequencer_if bus();

    morse_key_sequencer #(
        .TONE_DOT_CYCLES  (DOT_N),
        .TONE_DASH_CYCLES (DASH_N),
        .GAP_CYCLES       (GAP_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every accepted handshake must match the oldest expected symbol.
    always @(negedge clk) begin
        if (rst_n && bus.code_valid && bus.code_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", {23'd0, bus.code_err, bus.code_len, bus.code_bits}, 32'h1ff);
            end else begin
                chk("sb_symbol", {23'd0, bus.code_err, bus.code_len, bus.code_bits},
                    {23'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic m_clear();
        m_bits = '0;
        m_len  = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic m_app(input bit dash);
        if (m_len == 3'd5) m_ovf = 1'b1;
        else begin
            m_bits[m_len] = dash;
            m_len = m_len + 3'd1;
        end
    endtask

    task automatic push_sym();
        sb_q.push_back({m_ovf, m_len, m_bits});
        m_clear();
    endtask

    task automatic press(input logic [3:0] code, input int hold);
        @(posedge clk); #1;
        bus.key_val  = code;
        bus.key_trig = 1'b1;
        repeat (hold) @(posedge clk);
        #1 bus.key_trig = 1'b0;
    endtask

    task automatic elem(input bit dash);
        m_app(dash);
        press(dash ? K_DASH : K_DOT, 2);
    endtask

    // Counts cycles tone_on is high; returns on the first negedge after it falls.
    task automatic measure_tone(output int n);
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.tone_on) break;
        end
        while (bus.tone_on && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_sb();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("sb_drain", sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        logic [8:0] snap;
        logic       stable;

        bus.key_val    = '0;
        bus.key_trig   = 1'b0;
        bus.code_ready = 1'b1;
        m_clear();

        // 1: reset state, then reset mid-tone
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {bus.tone_on, bus.busy, bus.sym_len, bus.code_valid,
                              bus.code_bits, bus.code_len, bus.code_err}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        press(K_DOT, 2);
        @(negedge clk);
        chk("tone_before_reset", bus.tone_on, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {bus.tone_on, bus.busy, bus.sym_len, bus.code_valid,
                                    bus.code_bits, bus.code_len, bus.code_err}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {bus.busy, bus.sym_len, bus.tone_on}, 0);

        // 2: DOT then DASH, tone lengths and auto-commit gap
        elem(1'b0);
        measure_tone(n);
        chk("dot_tone_len", n, DOT_N);
        elem(1'b1);
        measure_tone(n);
        chk("dash_tone_len", n, DASH_N);
        push_sym();
        k = 0;
        while (!bus.code_valid && k < 100) begin
            k++;
            @(negedge clk);
        end
        chk("gap_len", k, GAP_N);
        wait_sb();

        // 3: key during tone dropped; held key gives one element
        elem(1'b0);
        press(K_DOT, 2);
        @(negedge clk);
        chk("drop_in_tone_len", bus.sym_len, 1);
        chk("drop_in_tone_busy", bus.busy, 1);
        k = 0;
        while (bus.tone_on && k < 50) begin
            @(negedge clk);
            k++;
        end
        m_app(1'b1);
        push_sym();
        press(K_DASH, 100);
        wait_sb();
        repeat (5) @(negedge clk);
        chk("held_key_single", bus.sym_len, 0);

        // 4: overflow after six dashes, then a clean symbol
        for (int i = 0; i < 6; i++) begin
            elem(1'b1);
            measure_tone(n);
        end
        chk("ovf_tone_len", n, DASH_N);
        chk("ovf_sym_len", bus.sym_len, 5);
        push_sym();
        wait_sb();
        elem(1'b0);
        measure_tone(n);
        push_sym();
        wait_sb();

        // 5: backspace then explicit commit; commit from idle
        elem(1'b0);
        measure_tone(n);
        elem(1'b1);
        measure_tone(n);
        press(K_BKSP, 2);
        m_len = m_len - 3'd1;
        m_bits[m_len] = 1'b0;
        repeat (2) @(negedge clk);
        chk("bksp_len", bus.sym_len, 1);
        press(K_COMMIT, 2);
        push_sym();
        wait_sb();
        press(K_COMMIT, 2);
        push_sym();
        wait_sb();

        // 6: decoder stall keeps the symbol stable and drops keys
        bus.code_ready = 1'b0;
        elem(1'b1);
        measure_tone(n);
        press(K_COMMIT, 2);
        push_sym();
        k = 0;
        while (!bus.code_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("stall_valid_seen", bus.code_valid, 1);
        snap = {bus.code_err, bus.code_len, bus.code_bits};
        chk("stall_symbol", snap, 9'b0_001_00001);
        press(K_DOT, 2);
        stable = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (!bus.code_valid || bus.tone_on || bus.sym_len != 3'd1 ||
                {bus.code_err, bus.code_len, bus.code_bits} != snap) stable = 1'b0;
        end
        chk("stall_stable", stable, 1);
        @(posedge clk); #1 bus.code_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("valid_fall", bus.code_valid, 0);
        chk("back_idle", {bus.busy, bus.sym_len}, 0);
        wait_sb();

        // 6b: element arriving on the gap-expiry cycle wins over commit
        elem(1'b0);
        measure_tone(n);
        repeat (GAP_N - 3) @(posedge clk);
        elem(1'b1);
        @(negedge clk);
        chk("expiry_key_tone", bus.tone_on, 1);
        chk("expiry_key_len", bus.sym_len, 2);
        chk("expiry_no_commit", bus.code_valid, 0);
        push_sym();
        wait_sb();

        chk("sb_empty_end", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
